// File: rtl/argmax_stream_if.sv
// Score-in / result-out handshake bundle for argmax_stream.
interface argmax_stream_if #(
    parameter int DATA_W = 8,
    parameter int N      = 10
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_max;
    logic [IDX_W-1:0]  out_index;
    logic [DATA_W-1:0] out_second;
    logic [IDX_W-1:0]  out_second_index;
    logic              out_second_valid;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_index,
               out_second, out_second_index, out_second_valid
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_index,
               out_second, out_second_index, out_second_valid
    );
endinterface

// File: rtl/argmax_stream.sv
// Streaming arg-max: tracks best and runner-up score (lowest index wins ties)
// over a frame of N scores, then holds the result until the sink accepts it.
module argmax_stream #(
    parameter int DATA_W = 8,
    parameter int N      = 10,
    parameter bit SIGNED = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    input logic            clear,
    argmax_stream_if.slave bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic [DATA_W-1:0] sec_q, sec_d;
    logic [IDX_W-1:0]  sec_idx_q, sec_idx_d;
    logic              sec_v_q, sec_v_d;
    logic              accept;

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    assign bus.in_ready = (state_q == ACC) && rst_n;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        sec_d      = sec_q;
        sec_idx_d  = sec_idx_q;
        sec_v_d    = sec_v_q;
        // Runner-up fields are zeroed whenever sec_v drops so the outputs read 0.
        if (clear) begin
            state_d   = ACC;
            cnt_d     = '0;
            sec_v_d   = 1'b0;
            sec_d     = '0;
            sec_idx_d = '0;
        end else if (accept) begin
            if (cnt_q == '0) begin
                best_d     = bus.in_data;
                best_idx_d = '0;
                sec_v_d    = 1'b0;
                sec_d      = '0;
                sec_idx_d  = '0;
            end else if (gt(bus.in_data, best_q)) begin
                sec_d      = best_q;
                sec_idx_d  = best_idx_q;
                sec_v_d    = 1'b1;
                best_d     = bus.in_data;
                best_idx_d = cnt_q;
            end else if (!sec_v_q || gt(bus.in_data, sec_q)) begin
                sec_d     = bus.in_data;
                sec_idx_d = cnt_q;
                sec_v_d   = 1'b1;
            end
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                state_d = HOLD;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == HOLD && bus.out_ready) begin
            state_d = ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ACC;
            cnt_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            sec_q      <= '0;
            sec_idx_q  <= '0;
            sec_v_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            sec_q      <= sec_d;
            sec_idx_q  <= sec_idx_d;
            sec_v_q    <= sec_v_d;
        end
    end

    assign bus.out_valid        = (state_q == HOLD);
    assign bus.out_max          = best_q;
    assign bus.out_index        = best_idx_q;
    assign bus.out_second       = sec_q;
    assign bus.out_second_index = sec_idx_q;
    assign bus.out_second_valid = sec_v_q;
endmodule
